// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default
// geometry/timing and the data word width.
package mem_pkg;
    localparam int WORD_W          = 32;
    localparam int DEPTH_DEFAULT   = 512;
    localparam int LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x WORD_W storage with synchronous write and registered read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // NOTE: the array and its read register are deliberately not reset so they map onto
    // RAM; the responder masks rdata_o until a read has completed.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Accepts one Read/Write request level, performs it LATENCY edges later and pulses mem_done.
// Define MEM_RANGE_CHECK_EN to add the mem_err port and suppress accesses with address >= DEPTH.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] Mdatain,
    output logic              mem_done
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic              mem_err
`endif
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, data_q;
    logic              wr_q;
    logic              rd_valid_q;
    logic              accept, access, in_range, mem_en;
    logic [AW-1:0]     mem_idx;
    logic [WORD_W-1:0] rd_data;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;

    assign in_range = (addr_q < WORD_W'(DEPTH));
    assign mem_err  = err_q;

    always_ff @(posedge Clock) begin
        if (clear) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && !in_range;
        end
    end
`else
    assign in_range = 1'b1;
`endif

    assign mem_idx = AW'(addr_q % WORD_W'(DEPTH));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = HOLD;
            HOLD:    if (!Read && !Write) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clear on the access edge abandons the access, so it must also gate the array enable.
    assign mem_en = access && in_range && !clear;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access && !wr_q) begin
                rd_valid_q <= in_range;
            end
        end
    end

    // Write wins when both levels are high at acceptance.
    always_ff @(posedge Clock) begin
        if (accept && !clear) begin
            addr_q <= address;
            data_q <= data_in;
            wr_q   <= Write;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (Clock),
        .en_i    (mem_en),
        .we_i    (wr_q),
        .addr_i  (mem_idx),
        .wdata_i (data_q),
        .rdata_o (rd_data)
    );

    assign Mdatain  = rd_valid_q ? rd_data : '0;
    assign mem_done = (state_q == DONE);
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by random accesses
// compared against a word-array reference model.
module tb_mem_responder;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 2;

    logic        Clock;
    logic        clear;
    logic        Read;
    logic        Write;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] Mdatain;
    logic        mem_done;
`ifdef MEM_RANGE_CHECK_EN
    logic        mem_err;
`endif

    mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .Clock    (Clock),
        .clear    (clear),
        .Read     (Read),
        .Write    (Write),
        .address  (address),
        .data_in  (data_in),
        .Mdatain  (Mdatain),
        .mem_done (mem_done)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .mem_err  (mem_err)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: word array with written-flags plus the expected Mdatain value.
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] exp_mdat;
    bit          exp_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a < 32'(DEPTH);
`else
        return (a == a);
`endif
    endfunction

    // One complete request; optionally pulses Write to address 3 while the request is in flight.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit disturb);
        int lat;
        bit inr;
        bit exp_err;
        int idx;
        @(negedge Clock);
        Read = rd; Write = wr; address = a; data_in = d;
        @(posedge Clock); #1;
        if (disturb) begin
            Read = 1'b0; Write = 1'b1; address = 32'h3; data_in = 32'hDEAD_BEEF;
        end else begin
            Read = 1'b0; Write = 1'b0; address = $urandom; data_in = $urandom;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clock); #1;
            Read = 1'b0; Write = 1'b0;
            if (mem_done) begin
                lat = k;
                break;
            end
        end
        inr     = ref_in_range(a);
        idx     = int'(a % 32'(DEPTH));
        exp_err = !inr;
        if (wr) begin
            if (inr) begin
                ref_mem[idx]   = d;
                ref_known[idx] = 1'b1;
            end
        end else if (!inr) begin
            exp_mdat  = '0;
            exp_known = 1'b1;
        end else begin
            exp_mdat  = ref_mem[idx];
            exp_known = ref_known[idx];
        end
        check("latency", 32'(lat), 32'(LATENCY));
        if (exp_known) check("mdatain", Mdatain, exp_mdat);
`ifdef MEM_RANGE_CHECK_EN
        check("mem_err", 32'(mem_err), 32'(exp_err));
`else
        if (exp_err) check("range_model", 32'(exp_err), 32'(0));
`endif
        @(posedge Clock); #1;
        check("done_width", 32'(mem_done), 32'(0));
        @(posedge Clock); #1;
    endtask

    initial begin
        int          n_pulse;
        int          op;
        logic [31:0] a;

        foreach (ref_known[i]) ref_known[i] = 1'b0;
        exp_mdat  = '0;
        exp_known = 1'b1;
        clear = 1'b1; Read = 1'b0; Write = 1'b0; address = '0; data_in = '0;

        repeat (3) @(posedge Clock);
        #1;
        check("rst_mdatain", Mdatain, 32'h0);
        check("rst_done", 32'(mem_done), 32'(0));
`ifdef MEM_RANGE_CHECK_EN
        check("rst_err", 32'(mem_err), 32'(0));
`endif
        @(negedge Clock);
        clear = 1'b0;

        // Basic write then read-back.
        access(1'b0, 1'b1, 32'h10, 32'h2A2B_8000, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("wr_rd_0x10", Mdatain, 32'h2A2B_8000);

        // A held Read level yields one access; a new one only after it drops for an edge.
        @(negedge Clock);
        Read = 1'b1; address = 32'h10;
        n_pulse = 0;
        repeat (6) begin
            @(posedge Clock); #1;
            if (mem_done) n_pulse++;
        end
        check("hold_one_pulse", 32'(n_pulse), 32'(1));
        check("hold_mdatain", Mdatain, 32'h2A2B_8000);
        @(negedge Clock);
        Read = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        Read = 1'b1;
        n_pulse = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (mem_done) n_pulse++;
        end
        check("rehold_pulse", 32'(n_pulse), 32'(1));
        @(negedge Clock);
        Read = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        // Read and Write together: write wins, Mdatain untouched.
        access(1'b1, 1'b1, 32'h4, 32'h22, 1'b0);
        check("both_mdat_kept", Mdatain, 32'h2A2B_8000);
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("both_readback", Mdatain, 32'h22);

        // clear on the would-be access edge abandons the pending write.
        access(1'b0, 1'b1, 32'h8, 32'h28, 1'b0);
        @(negedge Clock);
        Write = 1'b1; address = 32'h8; data_in = 32'h24;
        @(posedge Clock); #1;
        Write = 1'b0; address = '0; data_in = '0;
        @(posedge Clock); #1;
        clear = 1'b1;
        @(posedge Clock); #1;
        clear = 1'b0;
        check("clr_done", 32'(mem_done), 32'(0));
        check("clr_mdatain", Mdatain, 32'h0);
        exp_mdat  = '0;
        exp_known = 1'b1;
        n_pulse = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (mem_done) n_pulse++;
        end
        check("clr_no_done", 32'(n_pulse), 32'(0));
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        check("clr_rd8", Mdatain, 32'h28);

        // Address beyond DEPTH: wraps by default, rejected with range checking.
        access(1'b0, 1'b1, 32'h0, 32'h11, 1'b0);
        access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
        check("oor_mdatain", Mdatain, 32'h0);
`else
        check("wrap_mdatain", Mdatain, 32'h11);
`endif

        // Write pulsed while a read is in flight is ignored.
        access(1'b0, 1'b1, 32'h3, 32'h33, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        check("busy_rd_result", Mdatain, 32'h2A2B_8000);
        access(1'b1, 1'b0, 32'h3, 32'h0, 1'b0);
        check("busy_wr_ignored", Mdatain, 32'h33);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * int'($urandom_range(1, 3)));
            access(op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
